// File: rtl/controller_monitor.sv
// controller_monitor
//   Passive observer of the multicycle ARM controller. Every rising edge the
//   control vector is mapped back to a controller state and the transition
//   from the previously classified state is checked. Each completed
//   instruction produces a one-cycle record pulse.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   PCWrite .. ALUControl  controller outputs (RegSrc, ImmSrc, ALUControl unused)
//   cur_state          last classified state (0 IDLE .. 9 BRANCH)
//   rec_valid          one-cycle pulse, record fields valid
//   rec_class          0 DP_REG, 1 DP_IMM, 2 LDR, 3 STR, 4 BRANCH
//   rec_cycles         states spent, FETCH included (saturates at 15)
//   rec_taken          PCWrite seen in BRANCH
//   rec_regwr          instruction asserted RegWrite
//   instr_count        retired instructions, wraps
//   err, err_code      sticky error flag and code of the first error
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | after reset or error; waiting for a FETCH signature
// FETCH      | IRWrite cycle, starts an instruction
// DECODE     | register read / PC+8
// ADR_EXI    | address or immediate ALU op; class resolved by its successor
// EXECR      | register-register ALU op
// MEMRD      | data memory read
// MEMWB      | load write-back (terminal)
// MEMWR      | store (terminal)
// ALUWB      | ALU result write-back (terminal)
// BRANCH     | branch target (terminal)
module controller_monitor #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PCWrite,
   input  logic             MemWrite,
   input  logic             RegWrite,
   input  logic             IRWrite,
   input  logic             AdrSrc,
   input  logic [1:0]       RegSrc,
   input  logic [1:0]       ALUSrcA,
   input  logic [1:0]       ALUSrcB,
   input  logic [1:0]       ResultSrc,
   input  logic [1:0]       ImmSrc,
   input  logic [1:0]       ALUControl,
   output logic [3:0]       cur_state,
   output logic             rec_valid,
   output logic [2:0]       rec_class,
   output logic [3:0]       rec_cycles,
   output logic             rec_taken,
   output logic             rec_regwr,
   output logic [CNT_W-1:0] instr_count,
   output logic             err,
   output logic [2:0]       err_code
);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_ADR_EXI = 4'd3,
      ST_EXECR   = 4'd4,
      ST_MEMRD   = 4'd5,
      ST_MEMWB   = 4'd6,
      ST_MEMWR   = 4'd7,
      ST_ALUWB   = 4'd8,
      ST_BRANCH  = 4'd9,
      ST_ILLEGAL = 4'd15
   } state_t;

   localparam logic [2:0] C_DP_REG = 3'd0;
   localparam logic [2:0] C_DP_IMM = 3'd1;
   localparam logic [2:0] C_LDR    = 3'd2;
   localparam logic [2:0] C_STR    = 3'd3;
   localparam logic [2:0] C_BRANCH = 3'd4;

   logic unused_ctl;
   assign unused_ctl = ^{RegSrc, ImmSrc, ALUControl};

   state_t           cur_state_q, cur_state_d, sig;
   logic             fresh_q, fresh_d;
   logic [3:0]       cyc_q, cyc_d, cyc_inc;
   logic             regwr_q, regwr_d;
   logic             rec_valid_q, rec_valid_d;
   logic [2:0]       rec_class_q, rec_class_d;
   logic [3:0]       rec_cycles_q, rec_cycles_d;
   logic             rec_taken_q, rec_taken_d;
   logic             rec_regwr_q, rec_regwr_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic             err_q, err_d;
   logic [2:0]       err_code_q, err_code_d;
   logic             accept, legal, terminal, any_err;
   logic             e1, e2, e3, e4, e5;
   logic [2:0]       code;

   always_comb begin
      sig = ST_ILLEGAL;
      if (IRWrite)                                   sig = ST_FETCH;
      else if (MemWrite)                             sig = ST_MEMWR;
      else if (RegWrite && ResultSrc == 2'b01)       sig = ST_MEMWB;
      else if (RegWrite && ResultSrc == 2'b00)       sig = ST_ALUWB;
      else if (AdrSrc)                               sig = ST_MEMRD;
      else if (ALUSrcA == 2'b10)                     sig = ST_BRANCH;
      else if (ALUSrcA == 2'b01)                     sig = ST_DECODE;
      else if (ALUSrcA == 2'b00 && ALUSrcB == 2'b01) sig = ST_ADR_EXI;
      else if (ALUSrcA == 2'b00 && ALUSrcB == 2'b00) sig = ST_EXECR;
   end

   always_comb begin
      legal = 1'b0;
      case (cur_state_q)
         ST_IDLE:    legal = (sig == ST_FETCH);
         ST_FETCH:   legal = (sig == ST_DECODE);
         ST_DECODE:  legal = (sig == ST_ADR_EXI) || (sig == ST_EXECR) || (sig == ST_BRANCH);
         ST_ADR_EXI: legal = (sig == ST_MEMRD) || (sig == ST_MEMWR) || (sig == ST_ALUWB);
         ST_EXECR:   legal = (sig == ST_ALUWB);
         ST_MEMRD:   legal = (sig == ST_MEMWB);
         ST_MEMWB, ST_MEMWR, ST_ALUWB, ST_BRANCH: legal = (sig == ST_FETCH);
         default:    legal = 1'b0;
      endcase
   end

   // In IDLE a non-FETCH sample is only an error on the very first sample
   // after reset; after an error it is simply skipped while resyncing.
   always_comb begin
      accept = 1'b1;
      e2 = 1'b0;
      e3 = 1'b0;
      if (cur_state_q == ST_IDLE) begin
         if (sig != ST_FETCH) begin
            if (fresh_q) e3 = 1'b1;
            else         accept = 1'b0;
         end
      end else begin
         e2 = !legal;
      end
      e1 = accept && (sig == ST_ILLEGAL);
      e4 = accept && (sig == ST_FETCH) && (!PCWrite || AdrSrc);
      e5 = accept && PCWrite && (sig != ST_FETCH) && (sig != ST_BRANCH);
      any_err = e1 || e2 || e3 || e4 || e5;
      code = 3'd0;
      if (e1)      code = 3'd1;
      else if (e2) code = 3'd2;
      else if (e3) code = 3'd3;
      else if (e4) code = 3'd4;
      else if (e5) code = 3'd5;
   end

   assign terminal = (sig == ST_MEMWB) || (sig == ST_MEMWR) ||
                     (sig == ST_ALUWB) || (sig == ST_BRANCH);
   assign cyc_inc  = (cyc_q == 4'd15) ? 4'd15 : cyc_q + 4'd1;

   always_comb begin
      cur_state_d   = cur_state_q;
      fresh_d       = 1'b0;
      cyc_d         = cyc_q;
      regwr_d       = regwr_q;
      rec_valid_d   = 1'b0;
      rec_class_d   = rec_class_q;
      rec_cycles_d  = rec_cycles_q;
      rec_taken_d   = rec_taken_q;
      rec_regwr_d   = rec_regwr_q;
      instr_count_d = instr_count_q;
      err_d         = err_q || any_err;
      err_code_d    = err_q ? err_code_q : code;
      if (any_err) begin
         cur_state_d = ST_IDLE;
      end else if (accept) begin
         cur_state_d = sig;
         if (sig == ST_FETCH) begin
            cyc_d   = 4'd1;
            regwr_d = RegWrite;
         end else begin
            cyc_d   = cyc_inc;
            regwr_d = regwr_q || RegWrite;
         end
         if (terminal) begin
            rec_valid_d   = 1'b1;
            rec_cycles_d  = cyc_inc;
            rec_taken_d   = (sig == ST_BRANCH) && PCWrite;
            rec_regwr_d   = regwr_q || RegWrite;
            instr_count_d = instr_count_q + CNT_W'(1);
            case (sig)
               ST_MEMWB:  rec_class_d = C_LDR;
               ST_MEMWR:  rec_class_d = C_STR;
               ST_BRANCH: rec_class_d = C_BRANCH;
               default:   rec_class_d = (cur_state_q == ST_EXECR) ? C_DP_REG : C_DP_IMM;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state_q   <= ST_IDLE;
         fresh_q       <= 1'b1;
         cyc_q         <= 4'd0;
         regwr_q       <= 1'b0;
         rec_valid_q   <= 1'b0;
         rec_class_q   <= 3'd0;
         rec_cycles_q  <= 4'd0;
         rec_taken_q   <= 1'b0;
         rec_regwr_q   <= 1'b0;
         instr_count_q <= '0;
         err_q         <= 1'b0;
         err_code_q    <= 3'd0;
      end else begin
         cur_state_q   <= cur_state_d;
         fresh_q       <= fresh_d;
         cyc_q         <= cyc_d;
         regwr_q       <= regwr_d;
         rec_valid_q   <= rec_valid_d;
         rec_class_q   <= rec_class_d;
         rec_cycles_q  <= rec_cycles_d;
         rec_taken_q   <= rec_taken_d;
         rec_regwr_q   <= rec_regwr_d;
         instr_count_q <= instr_count_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
      end
   end

   assign cur_state   = cur_state_q;
   assign rec_valid   = rec_valid_q;
   assign rec_class   = rec_class_q;
   assign rec_cycles  = rec_cycles_q;
   assign rec_taken   = rec_taken_q;
   assign rec_regwr   = rec_regwr_q;
   assign instr_count = instr_count_q;
   assign err         = err_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_controller_monitor.sv
module tb_controller_monitor;

   localparam logic [3:0] S_I = 4'd0, S_F = 4'd1, S_D = 4'd2, S_A = 4'd3, S_X = 4'd4,
                          S_R = 4'd5, S_W = 4'd6, S_M = 4'd7, S_L = 4'd8, S_B = 4'd9,
                          S_ILL = 4'd15;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   logic [3:0]  cur_state, cur_state2;
   logic        rec_valid, rec_valid2;
   logic [2:0]  rec_class, rec_class2;
   logic [3:0]  rec_cycles, rec_cycles2;
   logic        rec_taken, rec_taken2, rec_regwr, rec_regwr2;
   logic [15:0] instr_count;
   logic [1:0]  instr_count2;
   logic        err, err2;
   logic [2:0]  err_code, err_code2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   controller_monitor #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .cur_state(cur_state), .rec_valid(rec_valid),
      .rec_class(rec_class), .rec_cycles(rec_cycles), .rec_taken(rec_taken),
      .rec_regwr(rec_regwr), .instr_count(instr_count), .err(err), .err_code(err_code)
   );

   controller_monitor #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .cur_state(cur_state2), .rec_valid(rec_valid2),
      .rec_class(rec_class2), .rec_cycles(rec_cycles2), .rec_taken(rec_taken2),
      .rec_regwr(rec_regwr2), .instr_count(instr_count2), .err(err2), .err_code(err_code2)
   );

   typedef struct packed {
      logic        rst;
      logic [3:0]  st;
      logic        pcw;
      logic [33:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic [3:0] st, logic pcw, logic [3:0] cur,
                               logic v, logic [2:0] cls, logic [3:0] cyc, logic tk,
                               logic rw, logic [15:0] cnt, logic e, logic [2:0] code);
      vec_t r;
      r.rst = rst;
      r.st  = st;
      r.pcw = pcw;
      r.exp = {cur, v, cls, cyc, tk, rw, cnt, e, code};
      return r;
   endfunction

   // Typical controller vector for each state; pcw overrides PCWrite.
   task automatic apply(input logic rst, input logic [3:0] st, input logic pcw);
      reset = rst;
      PCWrite = pcw; MemWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0;
      ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00;
      RegSrc = 2'($urandom_range(0, 3));
      ImmSrc = 2'($urandom_range(0, 3));
      ALUControl = 2'($urandom_range(0, 3));
      case (st)
         S_F: begin IRWrite = 1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
         S_D: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
         S_A: begin ALUSrcB = 2'b01; end
         S_X: begin end
         S_R: begin AdrSrc = 1; end
         S_W: begin RegWrite = 1; ResultSrc = 2'b01; end
         S_M: begin MemWrite = 1; AdrSrc = 1; end
         S_L: begin RegWrite = 1; end
         S_B: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; end
         default: begin ALUSrcA = 2'b11; end
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      apply(1, S_F, 1);
      apply(1, S_F, 1);
   endtask

   initial begin
      // rst st pcw | cur v cls cyc tk rw cnt err code
      vecs.push_back(mk(1, S_F, 1, S_I, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, S_F, 1, S_I, 0, 0, 0, 0, 0, 0, 0, 0));
      // LDR
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, S_A, 0, S_A, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, S_R, 0, S_R, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, S_W, 0, S_W, 1, 2, 5, 0, 1, 1, 0, 0));
      // STR
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 2, 5, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 2, 5, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, S_A, 0, S_A, 0, 2, 5, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, S_M, 0, S_M, 1, 3, 4, 0, 0, 2, 0, 0));
      // ADD immediate
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 3, 4, 0, 0, 2, 0, 0));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 3, 4, 0, 0, 2, 0, 0));
      vecs.push_back(mk(0, S_A, 0, S_A, 0, 3, 4, 0, 0, 2, 0, 0));
      vecs.push_back(mk(0, S_L, 0, S_L, 1, 1, 4, 0, 1, 3, 0, 0));
      // BEQ taken
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 1, 4, 0, 1, 3, 0, 0));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 1, 4, 0, 1, 3, 0, 0));
      vecs.push_back(mk(0, S_B, 1, S_B, 1, 4, 3, 1, 0, 4, 0, 0));
      // BEQ not taken
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 4, 3, 1, 0, 4, 0, 0));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 4, 3, 1, 0, 4, 0, 0));
      vecs.push_back(mk(0, S_B, 0, S_B, 1, 4, 3, 0, 0, 5, 0, 0));
      // illegal transition DECODE -> MEMRD
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 4, 3, 0, 0, 5, 0, 0));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 4, 3, 0, 0, 5, 0, 0));
      vecs.push_back(mk(0, S_R, 0, S_I, 0, 4, 3, 0, 0, 5, 1, 2));
      // DP_REG after resync
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 4, 3, 0, 0, 5, 1, 2));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 4, 3, 0, 0, 5, 1, 2));
      vecs.push_back(mk(0, S_X, 0, S_X, 0, 4, 3, 0, 0, 5, 1, 2));
      vecs.push_back(mk(0, S_L, 0, S_L, 1, 0, 4, 0, 1, 6, 1, 2));
      // reset mid-LDR, released on DECODE
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 0, 4, 0, 1, 6, 1, 2));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 0, 4, 0, 1, 6, 1, 2));
      vecs.push_back(mk(0, S_A, 0, S_A, 0, 0, 4, 0, 1, 6, 1, 2));
      vecs.push_back(mk(1, S_R, 0, S_I, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, S_D, 0, S_I, 0, 0, 0, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, S_F, 1, S_F, 0, 0, 0, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, S_D, 0, S_D, 0, 0, 0, 0, 0, 0, 1, 3));
      vecs.push_back(mk(0, S_B, 1, S_B, 1, 4, 3, 1, 0, 1, 1, 3));

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].st, vecs[i].pcw);
         check($sformatf("vec%0d", i),
               64'({cur_state, rec_valid, rec_class, rec_cycles, rec_taken,
                    rec_regwr, instr_count, err, err_code}),
               64'(vecs[i].exp));
      end

      // fresh ILLEGAL signature with PCWrite: codes 1, 3 and 5 coincide, 1 wins
      do_reset();
      apply(0, S_ILL, 1);
      check("illegal_code", 64'(err_code), 64'd1);
      check("illegal_state", 64'({err, cur_state}), 64'({1'b1, S_I}));

      // FETCH without PCWrite
      do_reset();
      apply(0, S_F, 0);
      check("fetch_nopc", 64'({err, err_code, cur_state}), 64'({1'b1, 3'd4, S_I}));

      // PCWrite in DECODE, then a later illegal transition must not overwrite the code
      do_reset();
      apply(0, S_F, 1);
      apply(0, S_D, 1);
      check("pc_decode", 64'({err, err_code, cur_state}), 64'({1'b1, 3'd5, S_I}));
      apply(0, S_A, 0);
      check("resync_skip", 64'({err_code, cur_state}), 64'({3'd5, S_I}));
      apply(0, S_F, 1);
      apply(0, S_D, 0);
      apply(0, S_R, 0);
      check("first_code_kept", 64'({err, err_code}), 64'({1'b1, 3'd5}));

      // codes 2 and 5 in one sample: 2 wins
      do_reset();
      apply(0, S_F, 1);
      apply(0, S_D, 0);
      apply(0, S_R, 1);
      check("prio_2_over_5", 64'(err_code), 64'd2);

      // error on a terminal sample suppresses the record
      do_reset();
      apply(0, S_F, 1);
      apply(0, S_D, 0);
      apply(0, S_A, 0);
      apply(0, S_L, 1);
      check("term_err_norec", 64'({rec_valid, instr_count, err, err_code}),
            64'({1'b0, 16'd0, 1'b1, 3'd5}));

      // record, then an error on the very next sample
      do_reset();
      apply(0, S_F, 1);
      apply(0, S_D, 0);
      apply(0, S_B, 0);
      check("rec_before_err", 64'({rec_valid, rec_class, rec_taken, instr_count, err}),
            64'({1'b1, 3'd4, 1'b0, 16'd1, 1'b0}));
      apply(0, S_D, 0);
      check("err_after_rec", 64'({rec_valid, rec_class, instr_count, err, err_code}),
            64'({1'b0, 3'd4, 16'd1, 1'b1, 3'd2}));

      // instruction counter wrap on the 2-bit instance
      do_reset();
      for (int k = 0; k < 5; k++) begin
         apply(0, S_F, 1);
         apply(0, S_D, 0);
         apply(0, S_B, 1);
         check($sformatf("wrap%0d", k), 64'(instr_count2), 64'((k + 1) % 4));
      end
      check("wrap_rec", 64'({cur_state2, rec_valid2, rec_class2, rec_cycles2, rec_taken2,
                             rec_regwr2, err2, err_code2}),
            64'({S_B, 1'b1, 3'd4, 4'd3, 1'b1, 1'b0, 1'b0, 3'd0}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
